// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: default character width and
// launch FSM state encodings.
package uart_pkg;

  localparam int PAYLOAD_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Character storage, wrap-around pointers, occupancy counter and registered
// empty/full flags. Optional occupancy port under UART_TX_FIFO_LEVEL_EN.
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [$clog2(DEPTH):0]   level,
`endif
  output logic                     full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic             push_s;
  logic             pop_s;

  // A full FIFO never accepts, even when a pop frees a slot this cycle.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (push_req && !full_r && !flush) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (pop_req && !empty_r) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage write; contents need no reset since the counter gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and flags; flush wins over a simultaneous push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign empty   = empty_r;
  assign full    = full_r;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign level   = count_r;
`endif

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO with launch FSM feeding a transmitter's enable/data inputs.
// Optional fifo_level occupancy output when UART_TX_FIFO_LEVEL_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        s_valid,
  input  logic [PAYLOAD_BITS-1:0]     s_data,
  output logic                        s_ready,
  input  logic                        flush,
  output logic                        tx_en,
  output logic [PAYLOAD_BITS-1:0]     tx_data,
  input  logic                        tx_busy,
  output logic                        fifo_empty,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`endif
  output logic                        fifo_full
);

  tx_state_e               state_r;
  tx_state_e               state_nxt_s;
  logic                    pop_s;
  logic                    load_s;
  logic [PAYLOAD_BITS-1:0] head_s;
  logic                    empty_s;
  logic                    full_s;
  logic                    tx_en_r;
  logic [PAYLOAD_BITS-1:0] tx_data_r;

  uart_fifo_mem #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .push_req (s_valid),
    .wr_data  (s_data),
    .pop_req  (pop_s),
    .rd_data  (head_s),
    .empty    (empty_s),
`ifdef UART_TX_FIFO_LEVEL_EN
    .level    (fifo_level),
`endif
    .full     (full_s)
  );

  // Launch FSM next-state; the head is popped on the IDLE->LAUNCH edge.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && !tx_busy) begin
          state_nxt_s = ST_LAUNCH;
          pop_s       = 1'b1;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered strobe/data; flush deliberately not used here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      tx_en_r   <= 1'b0;
      tx_data_r <= {PAYLOAD_BITS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      tx_en_r <= load_s;
      if (load_s) begin
        tx_data_r <= head_s;
      end
    end
  end

  assign tx_en      = tx_en_r;
  assign tx_data    = tx_data_r;
  assign fifo_empty = empty_s;
  assign fifo_full  = full_s;
  assign s_ready    = !full_s;

endmodule
